mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 4, memory address width (16 words).
REQ-002 Parameter DW, default 32, memory data width.
REQ-003 Parameter CYCLE_LIMIT, default 100, cycle count at which done asserts.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rstb  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  2  per-requester access request; bit i is requester i.
REQ-007 req_ready  output  2  per-requester grant/accept, one-hot or zero.
REQ-008 req_we  input  2  per-requester write enable (1 = write, 0 = read).
REQ-009 req_addr  input  2*AW  requester i address in bits [i*AW +: AW].
REQ-010 req_wdata  input  2*DW  requester i write data in bits [i*DW +: DW].
REQ-011 rsp_valid  output  2  one-cycle response strobe to requester i.
REQ-012 rsp_rdata  output  DW  response data, shared; valid only with rsp_valid.
REQ-013 mem_en  output  1  memory access strobe.
REQ-014 mem_we  output  1  memory write enable.
REQ-015 mem_addr  output  AW  memory address.
REQ-016 mem_wdata  output  DW  memory write data.
REQ-017 mem_rdata  input  DW  memory read data, valid exactly 1 cycle after mem_en with mem_we=0.
REQ-018 cycle  output  32  free-running cycle count.
REQ-019 done  output  1  sticky limit-reached flag.

Function
REQ-020 Arbitration SHALL be two-way round-robin with a 1-bit priority pointer ptr; ptr=0 favours requester 0.
REQ-021 Grant SHALL be combinational in the same cycle: one valid -> that requester; both valid -> requester ptr; none -> req_ready=2'b00.
REQ-022 Acceptance SHALL be req_valid[i] & req_ready[i]; at most one acceptance per cycle; throughput one access per cycle.
REQ-023 On acceptance mem_en=1 and mem_we/mem_addr/mem_wdata SHALL equal the granted requester's fields in that cycle; otherwise mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-024 ptr SHALL update only on acceptance, to the non-granted requester index; unchanged in idle cycles.
REQ-025 Response SHALL be registered: rsp_valid[i]=1 exactly one cycle after acceptance for requester i, for both reads and writes, zero otherwise.
REQ-026 rsp_rdata SHALL equal mem_rdata for a read response, 0 for a write response, and 0 when no response.
REQ-027 Back-to-back accesses SHALL pipeline: response for access N and issue of access N+1 occur in the same cycle without stall.
REQ-028 Requester data fields SHALL be ignored while req_valid is low; a non-granted requester must hold its request (no drop, no internal queue).
REQ-029 cycle SHALL increment by 1 every cycle out of reset and wrap 0xFFFFFFFF -> 0.
REQ-030 done SHALL assert on the cycle after cycle==CYCLE_LIMIT is registered and stay high until reset; arbitration continues after done.

Reset
REQ-031 While rstb=1: ptr=0, rsp_valid=0, rsp_rdata=0, cycle=0, done=0, any in-flight response discarded; req_ready=0 and mem_en=0 during reset cycles.
REQ-032 Reset asserted in the cycle after an acceptance SHALL suppress that response.

Verification
REQ-033 Only requester 0 reads addr 3 with mem_rdata=0xDEADBEEF -> req_ready=01, mem_en=1, mem_addr=3; next cycle rsp_valid=01, rsp_rdata=0xDEADBEEF.
REQ-034 Both valid continuously for 4 cycles, ptr=0 at start -> grants 0,1,0,1; rsp_valid 01,10,01,10 each one cycle later.
REQ-035 Requester 1 writes 0x12345678 to addr 15 -> mem_we=1, mem_wdata=0x12345678; next cycle rsp_valid=10, rsp_rdata=0.
REQ-036 Accept read, assert rstb next cycle -> rsp_valid stays 00, ptr=0, cycle=0.
REQ-037 Run from reset with CYCLE_LIMIT=100 -> done=0 through cycle==100, done=1 from next cycle and remains 1.
REQ-038 Idle 3 cycles after a grant to 0, then both valid -> requester 1 granted (ptr held).

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Requester, response and memory-side signals of the two-port arbiter.
// slave is the arbiter's view; master is the requester/memory model's view.
interface mem_arbiter_if #(
  parameter int AW = 4,
  parameter int DW = 32
);
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0]      req_we;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]      rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter onto one single-cycle memory port,
// with registered responses, a free-running cycle counter and a done flag.
module mem_arbiter #(
  parameter int AW          = 4,
  parameter int DW          = 32,
  parameter int CYCLE_LIMIT = 100
) (
  input  logic        clk,
  input  logic        rstb,
  mem_arbiter_if.slave bus,
  output logic [31:0] cycle,
  output logic        done
);

  logic          ptr;
  logic [1:0]    gnt;
  logic          sel;
  logic          acc;
  logic          we;
  logic [1:0]    rsp_q;
  logic          rsp_rd;

  always_comb begin
    gnt = 2'b00;
    if (!rstb) begin
      unique case (bus.req_valid)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign sel = gnt[1];
  assign acc = |gnt;
  assign we  = acc & (sel ? bus.req_we[1] : bus.req_we[0]);

  always_comb begin
    bus.req_ready = gnt;
    bus.mem_en    = acc;
    bus.mem_we    = we;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (acc) begin
      bus.mem_addr  = sel ? bus.req_addr[AW +: AW]
                          : bus.req_addr[0 +: AW];
      bus.mem_wdata = sel ? bus.req_wdata[DW +: DW]
                          : bus.req_wdata[0 +: DW];
    end
  end

  // Reset gates the response combinationally so an in-flight one is lost
  always_comb begin
    bus.rsp_valid = rstb ? 2'b00 : rsp_q;
    bus.rsp_rdata = '0;
    if (!rstb && |rsp_q && rsp_rd)
      bus.rsp_rdata = bus.mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      ptr    <= 1'b0;
      rsp_q  <= 2'b00;
      rsp_rd <= 1'b0;
      cycle  <= '0;
      done   <= 1'b0;
    end else begin
      cycle  <= cycle + 32'd1;
      rsp_q  <= gnt;
      rsp_rd <= acc & ~we;
      if (cycle == 32'(CYCLE_LIMIT))
        done <= 1'b1;
      if (acc)
        ptr <= gnt[0];
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed checks of grant, memory strobes, responses, reset and done.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_mem_arbiter;

  localparam int AW = 4;
  localparam int DW = 32;

  logic        clk = 1'b0;
  logic        rstb;
  logic [31:0] cycle;
  logic        done;
  int          nvec = 0;
  int          nbad = 0;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(
    .AW(AW), .DW(DW), .CYCLE_LIMIT(100)
  ) dut (
    .clk(clk),
    .rstb(rstb),
    .bus(bus.slave),
    .cycle(cycle),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = 2'b00;
    bus.req_we    = 2'b00;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.mem_rdata = '0;
  endtask

  task automatic do_reset();
    rstb = 1'b1;
    idle_inputs();
    tick();
    tick();
    rstb = 1'b0;
  endtask

  task automatic test_reset();
    rstb = 1'b1;
    idle_inputs();
    bus.req_valid = 2'b11;
    tick();
    tick();
    @(negedge clk);
    nvec++;
    if (bus.req_ready !== 2'b00) begin
      nbad++;
      $display("FAIL rst_ready got %b exp 00", bus.req_ready);
    end
    nvec++;
    if (bus.mem_en !== 1'b0) begin
      nbad++;
      $display("FAIL rst_mem_en got %b exp 0", bus.mem_en);
    end
    nvec++;
    if (bus.rsp_valid !== 2'b00 || bus.rsp_rdata !== '0) begin
      nbad++;
      $display("FAIL rst_rsp got %b/%h exp 00/0",
               bus.rsp_valid, bus.rsp_rdata);
    end
    nvec++;
    if (cycle !== 32'd0 || done !== 1'b0) begin
      nbad++;
      $display("FAIL rst_cnt got %0d/%b exp 0/0", cycle, done);
    end
    tick();
    rstb = 1'b0;
    idle_inputs();
  endtask

  task automatic test_read();
    do_reset();
    bus.req_valid = 2'b01;
    bus.req_addr  = 8'hA3;
    bus.req_wdata = {32'h1111_1111, 32'h2222_2222};
    @(negedge clk);
    nvec++;
    if (bus.req_ready !== 2'b01) begin
      nbad++;
      $display("FAIL rd_ready got %b exp 01", bus.req_ready);
    end
    nvec++;
    if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0
        || bus.mem_addr !== 4'd3) begin
      nbad++;
      $display("FAIL rd_mem got en%b we%b a%h exp en1 we0 a3",
               bus.mem_en, bus.mem_we, bus.mem_addr);
    end
    tick();
    idle_inputs();
    bus.mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    nvec++;
    if (bus.rsp_valid !== 2'b01) begin
      nbad++;
      $display("FAIL rd_rsp_valid got %b exp 01", bus.rsp_valid);
    end
    nvec++;
    if (bus.rsp_rdata !== 32'hDEAD_BEEF) begin
      nbad++;
      $display("FAIL rd_rsp_data got %h exp deadbeef",
               bus.rsp_rdata);
    end
    tick();
    @(negedge clk);
    nvec++;
    if (bus.rsp_valid !== 2'b00 || bus.rsp_rdata !== '0) begin
      nbad++;
      $display("FAIL rd_rsp_clear got %b/%h exp 00/0",
               bus.rsp_valid, bus.rsp_rdata);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]    eg [4];
    logic [AW-1:0] ea [4];
    eg = '{2'b01, 2'b10, 2'b01, 2'b10};
    ea = '{4'h1, 4'h2, 4'h1, 4'h2};
    do_reset();
    bus.req_valid = 2'b11;
    bus.req_addr  = 8'h21;
    for (int i = 0; i <= 4; i++) begin
      if (i == 4) bus.req_valid = 2'b00;
      bus.mem_rdata = 32'hA000_0000 + 32'(i);
      @(negedge clk);
      if (i < 4) begin
        nvec++;
        if (bus.req_ready !== eg[i]
            || bus.mem_addr !== ea[i]) begin
          nbad++;
          $display("FAIL rr_grant%0d got %b a%h exp %b a%h",
                   i, bus.req_ready, bus.mem_addr, eg[i], ea[i]);
        end
      end
      nvec++;
      if (i == 0) begin
        if (bus.rsp_valid !== 2'b00) begin
          nbad++;
          $display("FAIL rr_rsp0 got %b exp 00", bus.rsp_valid);
        end
      end else if (bus.rsp_valid !== eg[i-1]
                   || bus.rsp_rdata !== 32'hA000_0000 + 32'(i)) begin
        nbad++;
        $display("FAIL rr_rsp%0d got %b/%h exp %b/%h", i,
                 bus.rsp_valid, bus.rsp_rdata, eg[i-1],
                 32'hA000_0000 + 32'(i));
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_write();
    do_reset();
    bus.req_valid = 2'b10;
    bus.req_we    = 2'b10;
    bus.req_addr  = 8'hF0;
    bus.req_wdata = {32'h1234_5678, 32'h5555_5555};
    @(negedge clk);
    nvec++;
    if (bus.req_ready !== 2'b10 || bus.mem_we !== 1'b1) begin
      nbad++;
      $display("FAIL wr_grant got %b we%b exp 10 we1",
               bus.req_ready, bus.mem_we);
    end
    nvec++;
    if (bus.mem_addr !== 4'hF
        || bus.mem_wdata !== 32'h1234_5678) begin
      nbad++;
      $display("FAIL wr_mem got %h/%h exp f/12345678",
               bus.mem_addr, bus.mem_wdata);
    end
    tick();
    idle_inputs();
    bus.mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    nvec++;
    if (bus.rsp_valid !== 2'b10 || bus.rsp_rdata !== '0) begin
      nbad++;
      $display("FAIL wr_rsp got %b/%h exp 10/0",
               bus.rsp_valid, bus.rsp_rdata);
    end
    tick();
  endtask

  task automatic test_reset_inflight();
    do_reset();
    bus.req_valid = 2'b01;
    bus.req_addr  = 8'h05;
    tick();
    rstb = 1'b1;
    idle_inputs();
    bus.mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    nvec++;
    if (bus.rsp_valid !== 2'b00 || bus.rsp_rdata !== '0) begin
      nbad++;
      $display("FAIL rif_rsp got %b/%h exp 00/0",
               bus.rsp_valid, bus.rsp_rdata);
    end
    tick();
    @(negedge clk);
    nvec++;
    if (cycle !== 32'd0 || bus.rsp_valid !== 2'b00) begin
      nbad++;
      $display("FAIL rif_cnt got %0d/%b exp 0/00",
               cycle, bus.rsp_valid);
    end
    tick();
    rstb = 1'b0;
    bus.req_valid = 2'b11;
    @(negedge clk);
    nvec++;
    if (bus.req_ready !== 2'b01) begin
      nbad++;
      $display("FAIL rif_ptr got %b exp 01", bus.req_ready);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    nvec++;
    if (bus.rsp_valid !== 2'b01) begin
      nbad++;
      $display("FAIL rif_rsp2 got %b exp 01", bus.rsp_valid);
    end
    tick();
  endtask

  task automatic test_idle_hold();
    do_reset();
    bus.req_valid = 2'b01;
    tick();
    idle_inputs();
    bus.req_we    = 2'b11;
    bus.req_addr  = 8'h77;
    bus.req_wdata = {32'hCAFE_F00D, 32'hBAAD_F00D};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nvec++;
      if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0
          || bus.mem_addr !== '0 || bus.mem_wdata !== '0
          || bus.req_ready !== 2'b00) begin
        nbad++;
        $display("FAIL idle%0d got en%b we%b a%h d%h r%b exp 0",
                 i, bus.mem_en, bus.mem_we, bus.mem_addr,
                 bus.mem_wdata, bus.req_ready);
      end
      tick();
    end
    idle_inputs();
    bus.req_valid = 2'b11;
    @(negedge clk);
    nvec++;
    if (bus.req_ready !== 2'b10) begin
      nbad++;
      $display("FAIL idle_ptr got %b exp 10", bus.req_ready);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_done();
    do_reset();
    for (int n = 0; n <= 110; n++) begin
      @(negedge clk);
      nvec++;
      if (cycle !== 32'(n) || done !== (n > 100)) begin
        nbad++;
        $display("FAIL done_at%0d got %0d/%b exp %0d/%b",
                 n, cycle, done, n, n > 100);
      end
      tick();
    end
    bus.req_valid = 2'b10;
    @(negedge clk);
    nvec++;
    if (bus.req_ready !== 2'b10 || done !== 1'b1) begin
      nbad++;
      $display("FAIL done_arb got %b/%b exp 10/1",
               bus.req_ready, done);
    end
    tick();
    idle_inputs();
  endtask

  initial begin
    rstb = 1'b1;
    idle_inputs();
    test_reset();
    test_read();
    test_round_robin();
    test_write();
    test_reset_inflight();
    test_idle_hold();
    test_done();
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule
